// File: rtl/alu_pkg.sv
// Shared datapath constants for the ALU arithmetic path.
package alu_pkg;

  // Default datapath width.
  localparam int unsigned DATA_W = 32;

  // Operation select values for the adder's sub input.
  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/cla4.sv
// 4-bit carry-lookahead slice; also exports the carry into bit 3 so the top
// slice can form signed overflow.
module cla4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout,
  output logic       c3
);

  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  // Generate/propagate terms and flattened lookahead carries.
  always_comb begin
    g    = a & b;
    p    = a ^ b;
    c[0] = cin;
    c[1] = g[0] | (p[0] & cin);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & cin);
    sum  = p ^ c[3:0];
    cout = c[4];
    c3   = c[3];
  end

endmodule

// File: rtl/adder.sv
// Two's-complement adder/subtractor with combinational flags and a sticky
// signed-overflow register. Group carries ripple between 4-bit CLA slices.
module adder
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = DATA_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             sub,
  output logic [WIDTH-1:0] res,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic             neg,
  output logic             ovf_sticky
);

  localparam int unsigned NSLICE = WIDTH / 4;

  logic [WIDTH-1:0] be;
  logic [NSLICE:0]  cg;
  logic             c_msb_in;

  // Subtract is A + ~B + 1: invert B and feed sub in as the carry.
  assign be    = (sub == OP_SUB) ? ~B : B;
  assign cg[0] = sub;

  for (genvar i = 0; i < NSLICE; i++) begin : g_slice
    if (i == NSLICE - 1) begin : g_top
      cla4 u_cla4 (
        .a    (A[4*i +: 4]),
        .b    (be[4*i +: 4]),
        .cin  (cg[i]),
        .sum  (res[4*i +: 4]),
        .cout (cg[i+1]),
        .c3   (c_msb_in)
      );
    end else begin : g_low
      logic c3_unused;
      cla4 u_cla4 (
        .a    (A[4*i +: 4]),
        .b    (be[4*i +: 4]),
        .cin  (cg[i]),
        .sum  (res[4*i +: 4]),
        .cout (cg[i+1]),
        .c3   (c3_unused)
      );
    end
  end

  assign cout = cg[NSLICE];
  assign ovf  = cg[NSLICE] ^ c_msb_in;
  assign zero = (res == '0);
  assign neg  = res[WIDTH-1];

  // Sticky overflow: set by any sampled overflow, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_sticky <= 1'b0;
    end else if (ovf) begin
      ovf_sticky <= 1'b1;
    end
  end

endmodule

// File: tb/tb_adder.sv
// Self-checking bench for adder: directed WIDTH=4 vectors, reset behaviour of
// the sticky flag, and a WIDTH=32 random sweep against an arithmetic model.
module tb_adder;

  logic        clk;
  logic        rst;

  logic [3:0]  a4, b4, res4;
  logic        sub4, cout4, ovf4, zero4, neg4, st4;

  logic [31:0] a32, b32, res32;
  logic        sub32, cout32, ovf32, zero32, neg32, st32;

  int total = 0;
  int bad   = 0;

  logic st4_exp;
  logic st32_exp;

  adder #(.WIDTH(4)) u_dut4 (
    .clk        (clk),
    .rst        (rst),
    .A          (a4),
    .B          (b4),
    .sub        (sub4),
    .res        (res4),
    .cout       (cout4),
    .ovf        (ovf4),
    .zero       (zero4),
    .neg        (neg4),
    .ovf_sticky (st4)
  );

  adder u_dut32 (
    .clk        (clk),
    .rst        (rst),
    .A          (a32),
    .B          (b32),
    .sub        (sub32),
    .res        (res32),
    .cout       (cout32),
    .ovf        (ovf32),
    .zero       (zero32),
    .neg        (neg32),
    .ovf_sticky (st32)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Arithmetic model: full-width sum with a sign-rule overflow.
  function automatic void model(input int unsigned w, input logic [31:0] a,
                                input logic [31:0] b, input logic s,
                                output logic [31:0] r, output logic co,
                                output logic ov, output logic z, output logic n);
    logic [63:0] mask, bb, full;
    mask = (64'd1 << w) - 64'd1;
    bb   = s ? (~{32'b0, b} & mask) : {32'b0, b};
    full = {32'b0, a} + bb + {63'b0, s};
    r    = full[31:0] & mask[31:0];
    co   = full[w];
    n    = r[w-1];
    z    = (r == 32'd0);
    if (s) ov = (a[w-1] != b[w-1]) && (n != a[w-1]);
    else   ov = (a[w-1] == b[w-1]) && (n != a[w-1]);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Hold a 4-bit vector across two clock edges, then check all outputs.
  task automatic apply4(input logic [3:0] a, input logic [3:0] b, input logic s,
                        input logic [3:0] plan_res);
    logic [31:0] r;
    logic co, ov, z, n;
    a4 = a; b4 = b; sub4 = s;
    @(negedge clk);
    @(negedge clk);
    model(4, {28'b0, a}, {28'b0, b}, s, r, co, ov, z, n);
    check("w4_plan_res", {28'b0, res4}, {28'b0, plan_res});
    check("w4_res",  {28'b0, res4}, r);
    check("w4_cout", {31'b0, cout4}, {31'b0, co});
    check("w4_ovf",  {31'b0, ovf4},  {31'b0, ov});
    check("w4_zero", {31'b0, zero4}, {31'b0, z});
    check("w4_neg",  {31'b0, neg4},  {31'b0, n});
    st4_exp = st4_exp | ov;
    check("w4_sticky", {31'b0, st4}, {31'b0, st4_exp});
  endtask

  initial begin
    logic [31:0] r;
    logic co, ov, z, n;

    rst = 1'b1;
    a4 = 4'd0; b4 = 4'd0; sub4 = 1'b0;
    a32 = 32'd0; b32 = 32'd0; sub32 = 1'b0;
    st4_exp = 1'b0;
    st32_exp = 1'b0;

    #3;
    check("reset_sticky4",  {31'b0, st4},  32'd0);
    check("reset_sticky32", {31'b0, st32}, 32'd0);
    // Combinational path must work while reset is held.
    a4 = 4'b0011; b4 = 4'b0100;
    #1;
    check("res_during_reset", {28'b0, res4}, 32'd7);

    @(negedge clk);
    rst = 1'b0;

    apply4(4'b0001, 4'b0000, 1'b0, 4'b0001);
    apply4(4'b0001, 4'b0000, 1'b1, 4'b0001);
    apply4(4'b0001, 4'b0001, 1'b0, 4'b0010);
    apply4(4'b0001, 4'b0001, 1'b1, 4'b0000);
    apply4(4'b0100, 4'b0110, 1'b0, 4'b1010);
    apply4(4'b0100, 4'b0110, 1'b1, 4'b1110);
    apply4(4'b0010, 4'b1000, 1'b0, 4'b1010);
    apply4(4'b0010, 4'b1000, 1'b1, 4'b1010);

    // Asynchronous clear between edges.
    #2;
    rst = 1'b1;
    #1;
    check("async_clear", {31'b0, st4}, 32'd0);
    rst = 1'b0;
    st32_exp = 1'b0;
    // Current vector (2 - (-8)) still overflows, so the next edge re-sets.
    @(negedge clk);
    check("reset_after_pulse", {31'b0, st4}, 32'd1);

    // Reset held across an edge with ovf=1: reset wins.
    a4 = 4'b0100; b4 = 4'b0110; sub4 = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("ovf_held", {31'b0, ovf4}, 32'd1);
    check("reset_wins", {31'b0, st4}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("sticky_after_release", {31'b0, st4}, 32'd1);
    a4 = 4'b0001; b4 = 4'b0000;
    @(negedge clk);
    check("sticky_holds", {31'b0, st4}, 32'd1);

    // WIDTH=32 random sweep.
    for (int i = 0; i < 10000; i++) begin
      @(negedge clk);
      if (i % 1000 == 0) begin
        rst = 1'b1;
        #1;
        rst = 1'b0;
        st32_exp = 1'b0;
      end
      check("w32_sticky", {31'b0, st32}, {31'b0, st32_exp});
      a32   = $urandom;
      b32   = $urandom;
      sub32 = 1'($urandom_range(0, 1));
      if (i % 4 == 0) b32 = a32;
      if (i % 16 == 1) a32 = 32'h7fff_ffff;
      if (i % 16 == 2) a32 = 32'h8000_0000;
      #1;
      model(32, a32, b32, sub32, r, co, ov, z, n);
      check("w32_res",  res32, r);
      check("w32_cout", {31'b0, cout32}, {31'b0, co});
      check("w32_ovf",  {31'b0, ovf32},  {31'b0, ov});
      check("w32_zero", {31'b0, zero32}, {31'b0, z});
      check("w32_neg",  {31'b0, neg32},  {31'b0, n});
      st32_exp = st32_exp | ov;
    end
    @(negedge clk);
    check("w32_sticky_final", {31'b0, st32}, {31'b0, st32_exp});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
